// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the VGA receive path.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {SEARCH, HMEAS, VWAIT, LOCKED} vga_rx_state_t;

    typedef logic [11:0] pixel_t;

endpackage

// File: rtl/crc16_12b.sv
// One-pixel step of CRC-16/CCITT: 12 colour bits folded in LSB first.
module crc16_12b (
    input  logic [15:0]     crc_in,
    input  vga_pkg::pixel_t pixel,
    output logic [15:0]     crc_out
);
    import vga_pkg::*;

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 12; i++) begin
            crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ pixel[i]) ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive monitor: locks to HS/VS timing and recovers pixel coordinates and colour.
// Optional per-frame CRC of the recovered pixels is built when FRAME_CRC_EN is defined.
module vga_sync_decoder #(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_pkg::V_BP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            vga_hs,
    input  logic            vga_vs,
    input  vga_pkg::pixel_t vga_rgb,
    output logic [9:0]      rx_x,
    output logic [9:0]      rx_y,
    output vga_pkg::pixel_t rx_pixel,
    output logic            rx_valid,
    output logic            locked,
    output logic            frame_start,
    output logic            sync_err,
    output logic [15:0]     frame_cnt,
    output logic [15:0]     frame_crc
);
    import vga_pkg::*;

    localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HLast     = 11'(HTotal - 1);
    localparam logic [10:0] HSyncLast = 11'(H_SYNC - 1);
    localparam logic [10:0] HStartC   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] HEndC     = 11'(H_SYNC + H_BP + H_VISIBLE);
    localparam logic [10:0] HSat      = 11'd2047;
    localparam logic [9:0]  VLast     = 10'(VTotal - 1);
    localparam logic [9:0]  VSyncLast = 10'(V_SYNC - 1);
    localparam logic [9:0]  VStartC   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  VEndC     = 10'(V_SYNC + V_BP + V_VISIBLE);

    logic          hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q;
    pixel_t        rgb_s1_q;
    logic [10:0]   h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic          vs_zeroed_q, vs_zeroed_d;
    logic          hgood_q, hgood_d;
    vga_rx_state_t state_q, state_d;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        violation, rx_valid_d, frame_start_d;
    logic [10:0] x_full;
    logic [9:0]  y_full;

    always_comb begin
        hs_fall = hs_s2_q & ~hs_s1_q;
        hs_rise = ~hs_s2_q & hs_s1_q;
        vs_fall = vs_s2_q & ~vs_s1_q;
        vs_rise = ~vs_s2_q & vs_s1_q;

        h_cnt_d = hs_fall ? 11'd0 : ((h_cnt_q == HSat) ? h_cnt_q : h_cnt_q + 11'd1);

        // The first line that starts with VS low is line 0 of the frame.
        v_cnt_d = v_cnt_q;
        if (hs_fall) begin
            if (!vs_s1_q && !vs_zeroed_q) begin
                v_cnt_d = 10'd0;
            end else if (v_cnt_q != 10'h3FF) begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end
        vs_zeroed_d = ~vs_s1_q & (vs_zeroed_q | hs_fall);

        violation = 1'b0;
        if (state_q == LOCKED) begin
            violation = (hs_fall && h_cnt_q != HLast) ||
                        (hs_rise && h_cnt_q != HSyncLast) ||
                        (vs_fall && v_cnt_q != VLast) ||
                        (vs_rise && v_cnt_q != VSyncLast) ||
                        (!hs_fall && h_cnt_q == HSat - 11'd1);
        end

        state_d = state_q;
        hgood_d = hgood_q;
        case (state_q)
            SEARCH: begin
                if (hs_fall) begin
                    state_d = HMEAS;
                    hgood_d = 1'b0;
                end
            end
            HMEAS: begin
                if (hs_fall) begin
                    if (h_cnt_q == HLast) begin
                        if (hgood_q) state_d = VWAIT;
                        else         hgood_d = 1'b1;
                    end else begin
                        hgood_d = 1'b0;
                    end
                end
            end
            VWAIT:   if (vs_fall) state_d = LOCKED;
            LOCKED:  if (violation) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase

        x_full        = h_cnt_d - HStartC;
        y_full        = v_cnt_d - VStartC;
        rx_valid_d    = (state_d == LOCKED) && h_cnt_d >= HStartC && h_cnt_d < HEndC &&
                        v_cnt_d >= VStartC && v_cnt_d < VEndC;
        frame_start_d = rx_valid_d && h_cnt_d == HStartC && v_cnt_d == VStartC;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Sync pins idle high, so the pipeline resets to that level.
            hs_s1_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            hs_s2_q     <= 1'b1;
            vs_s2_q     <= 1'b1;
            rgb_s1_q    <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            vs_zeroed_q <= 1'b0;
            hgood_q     <= 1'b0;
            state_q     <= SEARCH;
            rx_x        <= '0;
            rx_y        <= '0;
            rx_pixel    <= '0;
            rx_valid    <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hs_s1_q     <= vga_hs;
            vs_s1_q     <= vga_vs;
            hs_s2_q     <= hs_s1_q;
            vs_s2_q     <= vs_s1_q;
            rgb_s1_q    <= vga_rgb;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            vs_zeroed_q <= vs_zeroed_d;
            hgood_q     <= hgood_d;
            state_q     <= state_d;
            rx_x        <= x_full[9:0];
            rx_y        <= y_full;
            rx_pixel    <= rgb_s1_q;
            rx_valid    <= rx_valid_d;
            locked      <= (state_d == LOCKED);
            frame_start <= frame_start_d;
            sync_err    <= violation;
            if (frame_start_d) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc_acc_q, crc_seed, crc_next;

    // Pixel (0,0) starts a fresh accumulation while the finished value is published.
    assign crc_seed = frame_start_d ? CRC_INIT : crc_acc_q;

    crc16_12b u_crc (
        .crc_in  (crc_seed),
        .pixel   (rgb_s1_q),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_acc_q <= CRC_INIT;
            frame_crc <= '0;
        end else begin
            if (frame_start_d) frame_crc <= crc_acc_q;
            if (state_d != LOCKED) begin
                crc_acc_q <= CRC_INIT;
            end else if (rx_valid_d) begin
                crc_acc_q <= crc_next;
            end
        end
    end
`else
    assign frame_crc = '0;
`endif

endmodule
